sys_ctrl_param: RTL

Parametrised single-FSM system controller between the UART RX/TX and the register file/ALU.
- Parses multi-byte command frames from the UART receiver.
- Drives register-file write/read and ALU operations.
- Serialises results (register byte or multi-byte ALU result) to the UART transmitter.
- Generalises the fixed 8-bit/2-byte controller to configurable widths.
- Adds a result-pending stall, invalid-command detection and an optional inter-byte timeout.

---
 rtl/sys_ctrl_param.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_param.sv
// sys_ctrl_param: system controller between the UART RX/TX and the register file/ALU.
//
// Parses command frames arriving one byte per RX_D_VLD strobe:
//   0xAA addr data    register write
//   0xBB addr         register read, read byte is returned over UART TX
//   0xCC A B fun      write A to reg 0 and B to reg 1, then run the ALU
//   0xDD fun          run the ALU on the current operands
// Results (one read byte or ALU_BYTES ALU bytes) are held in a result buffer
// and drained to the transmitter LSB byte first, in parallel with parsing.
//
// Ports:
//   CLK, RST                   clock, synchronous active-low reset
//   RX_P_Data, RX_D_VLD        received byte and its one-cycle strobe
//   ALU_OUT, ALU_OUT_VLD       ALU result and its valid
//   RdData, RdData_VLD         register-file read data and its valid
//   Busy                       UART transmitter busy
//   ALU_EN, ALU_FUN, CLK_EN    ALU start pulse, function, clock-gate enable
//   Address, WrEn, RdEn, WrData  register-file access
//   TX_P_Data, TX_D_VLD        byte to transmit and its one-cycle strobe
//   CLK_div_en                 UART clock-divider enable (1 once out of reset)
//   Frame_Err                  one-cycle pulse on a rejected byte or frame
//   dbg_state_o                current FSM state
//
// Handshake semantics: there is no ready/backpressure on any interface.
// RX_D_VLD, WrEn, RdEn, ALU_EN and TX_D_VLD are single-cycle strobes that
// qualify their data in the same cycle. RdData_VLD / ALU_OUT_VLD are sampled
// only while a read / ALU operation is outstanding. A transmitted byte is
// considered consumed once Busy has been seen high and then low again.
//
// Optional build macro SYS_CTRL_TIMEOUT_EN: abandons a partial frame after
// TIMEOUT_CYC cycles of RX silence.

module sys_ctrl_param #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int ALU_BYTES   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [DATA_W-1:0]           RX_P_Data,
  input  logic                        RX_D_VLD,
  input  logic [ALU_BYTES*DATA_W-1:0] ALU_OUT,
  input  logic                        ALU_OUT_VLD,
  input  logic [DATA_W-1:0]           RdData,
  input  logic                        RdData_VLD,
  input  logic                        Busy,
  output logic                        ALU_EN,
  output logic [FUN_W-1:0]            ALU_FUN,
  output logic                        CLK_EN,
  output logic [ADDR_W-1:0]           Address,
  output logic                        WrEn,
  output logic                        RdEn,
  output logic [DATA_W-1:0]           WrData,
  output logic [DATA_W-1:0]           TX_P_Data,
  output logic                        TX_D_VLD,
  output logic                        CLK_div_en,
  output logic                        Frame_Err,
  output logic [3:0]                  dbg_state_o
);

  localparam int RES_W = ALU_BYTES * DATA_W;
  localparam int CNT_W = 4;

  localparam logic [DATA_W-1:0] CMD_WR  = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD  = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_NOP = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_ADDR   = 4'd1,
    WR_DATA   = 4'd2,
    RD_ADDR   = 4'd3,
    RD_WAIT   = 4'd4,
    OP_A      = 4'd5,
    OP_B      = 4'd6,
    ALU_FUN_S = 4'd7,
    ALU_WAIT  = 4'd8,
    STALL     = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic                pend_rd_q, pend_rd_d;   // operation parked in STALL: 1 read, 0 ALU
  logic                alu_en_q, alu_en_d;
  logic [FUN_W-1:0]    alu_fun_q, alu_fun_d;
  logic                clk_en_q, clk_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_vld_q, tx_vld_d;
  logic                div_en_q, div_en_d;
  logic                ferr_q, ferr_d;
  logic [RES_W-1:0]    res_q, res_d;           // result buffer, next byte in the LSBs
  logic [CNT_W-1:0]    cnt_q, cnt_d;           // bytes left in the buffer
  logic                infl_q, infl_d;         // a byte has been handed to TX
  logic                seen_q, seen_d;         // Busy went high for the in-flight byte
  logic                load_rd, load_alu;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            in_frame;
`endif

  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    clk_en_d  = clk_en_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    div_en_d  = 1'b1;
    ferr_d    = 1'b0;
    res_d     = res_q;
    cnt_d     = cnt_q;
    infl_d    = infl_q;
    seen_d    = seen_q;
    load_rd   = 1'b0;
    load_alu  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_Data == CMD_WR)       state_d = WR_ADDR;
          else if (RX_P_Data == CMD_RD)  state_d = RD_ADDR;
          else if (RX_P_Data == CMD_ALU) state_d = OP_A;
          else if (RX_P_Data == CMD_NOP) state_d = ALU_FUN_S;
          else                           ferr_d  = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_Data[ADDR_W-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          wr_data_d = RX_P_Data;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d = RX_P_Data[ADDR_W-1:0];
          // An undrained result would be overwritten by the read data.
          if (cnt_q != '0) begin
            pend_rd_d = 1'b1;
            state_d   = STALL;
          end else begin
            rd_en_d = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (RX_D_VLD) ferr_d = 1'b1;
        if (RdData_VLD) begin
          load_rd = 1'b1;
          state_d = IDLE;
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_W'(0);
          wr_data_d = RX_P_Data;
          state_d   = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          addr_d    = ADDR_W'(1);
          wr_data_d = RX_P_Data;
          state_d   = ALU_FUN_S;
        end
      end
      ALU_FUN_S: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_Data[FUN_W-1:0];
          if (cnt_q != '0) begin
            pend_rd_d = 1'b0;
            state_d   = STALL;
          end else begin
            alu_en_d = 1'b1;
            clk_en_d = 1'b1;
            state_d  = ALU_WAIT;
          end
        end
      end
      ALU_WAIT: begin
        if (RX_D_VLD) ferr_d = 1'b1;
        // CLK_EN drops the cycle after the result is taken.
        if (ALU_OUT_VLD) begin
          load_alu = 1'b1;
          clk_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      STALL: begin
        if (RX_D_VLD) ferr_d = 1'b1;
        if (cnt_q == '0) begin
          if (pend_rd_q) begin
            rd_en_d = 1'b1;
            state_d = RD_WAIT;
          end else begin
            alu_en_d = 1'b1;
            clk_en_d = 1'b1;
            state_d  = ALU_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef SYS_CTRL_TIMEOUT_EN
    in_frame = (state_q == WR_ADDR) || (state_q == WR_DATA) || (state_q == RD_ADDR) ||
               (state_q == OP_A) || (state_q == OP_B) || (state_q == ALU_FUN_S);
    to_cnt_d = '0;
    if (in_frame && !RX_D_VLD) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        // No byte arrived this cycle, so no strobe was scheduled above.
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif

    // TX drain. A load only happens while the buffer is empty, and it takes
    // priority over the final Busy fall of a previous result.
    if (load_rd || load_alu) begin
      res_d  = '0;
      if (load_rd) begin
        res_d[DATA_W-1:0] = RdData;
        cnt_d             = CNT_W'(1);
      end else begin
        res_d = ALU_OUT;
        cnt_d = CNT_W'(ALU_BYTES);
      end
      infl_d = 1'b0;
      seen_d = 1'b0;
    end else if (infl_q) begin
      if (Busy) seen_d = 1'b1;
      if (seen_q && !Busy) begin
        infl_d = 1'b0;
        seen_d = 1'b0;
        res_d  = res_q >> DATA_W;
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end else if (cnt_q != '0 && !Busy) begin
      tx_vld_d  = 1'b1;
      tx_data_d = res_q[DATA_W-1:0];
      infl_d    = 1'b1;
      seen_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      pend_rd_q <= 1'b0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      clk_en_q  <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      div_en_q  <= 1'b0;
      ferr_q    <= 1'b0;
      res_q     <= '0;
      cnt_q     <= '0;
      infl_q    <= 1'b0;
      seen_q    <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      clk_en_q  <= clk_en_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      div_en_q  <= div_en_d;
      ferr_q    <= ferr_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      infl_q    <= infl_d;
      seen_q    <= seen_d;
`ifdef SYS_CTRL_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_EN      = clk_en_q;
  assign Address     = addr_q;
  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign WrData      = wr_data_q;
  assign TX_P_Data   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign CLK_div_en  = div_en_q;
  assign Frame_Err   = ferr_q;
  assign dbg_state_o = state_q;

endmodule
